// File: rtl/jogo_sequencia_param_if.sv
// Player-side bundle of the sequence game.
// master drives iniciar/modo/chaves; slave is the game.
interface jogo_sequencia_param_if #(
  parameter int N_BOTOES  = 4,
  parameter int N_JOGADAS = 16
);
  localparam int W = $clog2(N_JOGADAS);

  logic                iniciar;
  logic                modo;
  logic [N_BOTOES-1:0] chaves;
  logic                acertou;
  logic                errou;
  logic                pronto;
  logic                timeout;
  logic [N_BOTOES-1:0] leds;
  logic [3:0]          db_estado;
  logic [W-1:0]        db_jogada;
  logic [W-1:0]        db_rodada;
  logic                db_igual;

  modport master (
    output iniciar, modo, chaves,
    input  acertou, errou, pronto, timeout,
    input  leds, db_estado, db_jogada,
    input  db_rodada, db_igual
  );

  modport slave (
    input  iniciar, modo, chaves,
    output acertou, errou, pronto, timeout,
    output leds, db_estado, db_jogada,
    output db_rodada, db_igual
  );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Memory-sequence game: control FSM plus datapath.
// Optional per-play timeout: define JOGO_TIMEOUT_EN.
module jogo_sequencia_param #(
  parameter int N_BOTOES       = 4,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic                   clock,
  input  logic                   reset,
  jogo_sequencia_param_if.slave  bus
);
  localparam int W = $clog2(N_JOGADAS);
  localparam logic [N_BOTOES-1:0] UM =
    {{(N_BOTOES-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    ESPERA      = 4'd2,
    REGISTRA    = 4'd3,
    COMPARA     = 4'd4,
    PROX_JOGADA = 4'd5,
    PROX_RODADA = 4'd6,
    FIM_ACERTO  = 4'd8,
    FIM_ERRO    = 4'd9,
    FIM_TIMEOUT = 4'd10
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [W-1:0]        r_jogada;
  logic [W-1:0]        r_rodada;
  logic                r_modo;
  logic [N_BOTOES-1:0] r_chaves_ant;
  logic [N_BOTOES-1:0] r_play;
  logic [31:0]         w_idx;
  logic [N_BOTOES-1:0] w_esperado;
  logic [W-1:0]        w_limite;
  logic                w_jogada_feita;
  logic                w_igual;
  logic                w_estourou;

  assign w_idx      = 32'(r_jogada) % 32'(N_BOTOES);
  assign w_esperado = UM << w_idx;
  assign w_igual    = (r_play == w_esperado);
  assign w_limite   = r_modo ? r_rodada
                             : W'(N_JOGADAS - 1);
  assign w_jogada_feita = (|bus.chaves) &&
                          !(|r_chaves_ant);

`ifdef JOGO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  logic [CW-1:0] r_cnt;

  // wait counter: zero outside espera, counts inside it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (r_estado == ESPERA)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end

  assign w_estourou  = (r_cnt == CW'(TIMEOUT_CICLOS - 1));
  assign bus.timeout = (r_estado == FIM_TIMEOUT);
`else
  assign w_estourou  = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_estado <= INICIAL;
    else
      r_estado <= w_prox;
  end

  // next-state logic
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      INICIAL:
        if (bus.iniciar) w_prox = PREPARACAO;
      PREPARACAO:
        w_prox = ESPERA;
      ESPERA:
        if (w_jogada_feita)  w_prox = REGISTRA;
        else if (w_estourou) w_prox = FIM_TIMEOUT;
      REGISTRA:
        w_prox = COMPARA;
      COMPARA:
        if (!w_igual)
          w_prox = FIM_ERRO;
        else if (r_jogada == w_limite)
          w_prox = (!r_modo ||
                    r_rodada == W'(N_JOGADAS - 1))
                   ? FIM_ACERTO : PROX_RODADA;
        else
          w_prox = PROX_JOGADA;
      PROX_JOGADA, PROX_RODADA:
        w_prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        if (bus.iniciar) w_prox = PREPARACAO;
      default:
        w_prox = INICIAL;
    endcase
  end

  // datapath: edge detector, play register, indices
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chaves_ant <= '0;
      r_play       <= '0;
      r_jogada     <= '0;
      r_rodada     <= '0;
      r_modo       <= 1'b0;
    end else begin
      r_chaves_ant <= bus.chaves;
      unique case (r_estado)
        PREPARACAO: begin
          r_play   <= '0;
          r_jogada <= '0;
          r_rodada <= '0;
          r_modo   <= bus.modo;
        end
        REGISTRA:
          r_play <= bus.chaves;
        PROX_JOGADA:
          r_jogada <= r_jogada + 1'b1;
        PROX_RODADA: begin
          r_rodada <= r_rodada + 1'b1;
          r_jogada <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pronto    = (r_estado == FIM_ACERTO) ||
                         (r_estado == FIM_ERRO)   ||
                         (r_estado == FIM_TIMEOUT);
  assign bus.acertou   = (r_estado == FIM_ACERTO);
  assign bus.errou     = (r_estado == FIM_ERRO) ||
                         (r_estado == FIM_TIMEOUT);
  assign bus.leds      = r_play;
  assign bus.db_estado = r_estado;
  assign bus.db_jogada = r_jogada;
  assign bus.db_rodada = r_rodada;
  assign bus.db_igual  = w_igual;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: game outcomes via a
// scoreboard popped on each rising pronto, plus direct checks.
module tb_jogo_sequencia_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jogo_sequencia_param_if #(.N_BOTOES(4), .N_JOGADAS(16)) if1();
  jogo_sequencia_param_if #(.N_BOTOES(4), .N_JOGADAS(4))  if2();

  jogo_sequencia_param #(
    .N_BOTOES(4), .N_JOGADAS(16), .TIMEOUT_CICLOS(3000)
  ) u_dut1 (.clock(clk), .reset(rst_n), .bus(if1));

  jogo_sequencia_param #(
    .N_BOTOES(4), .N_JOGADAS(4), .TIMEOUT_CICLOS(3000)
  ) u_dut2 (.clock(clk), .reset(rst_n), .bus(if2));

  typedef struct packed {
    logic [3:0] est;
    logic       ac;
    logic       er;
    logic       to;
    logic [3:0] jog;
    logic [3:0] rod;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic p1_prev = 1'b0;
  logic p2_prev = 1'b0;

  task automatic chk(input string nome,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nome, act, exp);
  endtask

  task automatic pop_cmp(input string tag,
                         input logic [3:0] est,
                         input logic ac, input logic er,
                         input logic to,
                         input logic [3:0] jog,
                         input logic [3:0] rod);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s unexpected_end: estado %0d", tag, est);
    end else begin
      e = sb.pop_front();
      chk({tag, ".estado"},  32'(est), 32'(e.est));
      chk({tag, ".acertou"}, 32'(ac),  32'(e.ac));
      chk({tag, ".errou"},   32'(er),  32'(e.er));
      chk({tag, ".timeout"}, 32'(to),  32'(e.to));
      chk({tag, ".jogada"},  32'(jog), 32'(e.jog));
      chk({tag, ".rodada"},  32'(rod), 32'(e.rod));
    end
  endtask

  always @(negedge clk) begin
    if (if1.pronto && !p1_prev)
      pop_cmp("dut1", if1.db_estado, if1.acertou, if1.errou,
              if1.timeout, if1.db_jogada, if1.db_rodada);
    p1_prev = if1.pronto;
  end

  always @(negedge clk) begin
    if (if2.pronto && !p2_prev)
      pop_cmp("dut2", if2.db_estado, if2.acertou, if2.errou,
              if2.timeout, {2'b00, if2.db_jogada},
              {2'b00, if2.db_rodada});
    p2_prev = if2.pronto;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input logic [3:0] est,
                            input logic ac, input logic er,
                            input logic to,
                            input logic [3:0] jog,
                            input logic [3:0] rod);
    exp_t e;
    e.est = est; e.ac = ac; e.er = er; e.to = to;
    e.jog = jog; e.rod = rod;
    sb.push_back(e);
  endtask

  task automatic drain(input string nome);
    int i;
    for (i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL %s: no end seen, pending %0d expected 0",
               nome, sb.size());
      sb.delete();
    end
  endtask

  task automatic jogar(input int dut, input logic [3:0] p);
    if (dut == 1) if1.chaves = p; else if2.chaves = p;
    tick(10);
    if (dut == 1) if1.chaves = '0; else if2.chaves = '0;
    tick(10);
  endtask

  task automatic iniciar(input int dut, input logic m);
    if (dut == 1) begin
      if1.modo = m; if1.iniciar = 1'b1;
      tick(5);
      if1.iniciar = 1'b0;
    end else begin
      if2.modo = m; if2.iniciar = 1'b1;
      tick(5);
      if2.iniciar = 1'b0;
    end
    tick(5);
  endtask

  initial begin
    logic [3:0] um;
    int c;
    int i;
    um = 4'b0001;
    if1.iniciar = 1'b0; if1.modo = 1'b0; if1.chaves = '0;
    if2.iniciar = 1'b0; if2.modo = 1'b0; if2.chaves = '0;

    // reset state
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("rst.estado",  32'(if1.db_estado), 32'd0);
    chk("rst.jogada",  32'(if1.db_jogada), 32'd0);
    chk("rst.rodada",  32'(if1.db_rodada), 32'd0);
    chk("rst.pronto",  32'(if1.pronto),    32'd0);
    chk("rst.acertou", 32'(if1.acertou),   32'd0);
    chk("rst.errou",   32'(if1.errou),     32'd0);
    chk("rst.timeout", 32'(if1.timeout),   32'd0);
    chk("rst.leds",    32'(if1.leds),      32'd0);
    chk("rst.igual",   32'(if1.db_igual),  32'd0);

    // fixed mode, all 16 plays correct
    iniciar(1, 1'b0);
    chk("prep.estado", 32'(if1.db_estado), 32'd2);
    expect_end(4'd8, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0);
    for (int k = 0; k < 16; k++) jogar(1, um << (k % 4));
    drain("acerto16");
    chk("acerto16.leds", 32'(if1.leds), 32'h8);

    // restart from end state; wrong 4th play
    iniciar(1, 1'b0);
    expect_end(4'd9, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0);
    jogar(1, 4'b0001); jogar(1, 4'b0010);
    jogar(1, 4'b0100); jogar(1, 4'b0001);
    drain("erro4");
    chk("erro4.igual", 32'(if1.db_igual), 32'd0);
    chk("erro4.leds",  32'(if1.leds),     32'h1);

    // multi-bit switch value is a wrong play
    iniciar(1, 1'b0);
    expect_end(4'd9, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    jogar(1, 4'b0011);
    drain("multibit");

    // reset during play 5, then restart
    iniciar(1, 1'b0);
    jogar(1, 4'b0001); jogar(1, 4'b0010);
    jogar(1, 4'b0100); jogar(1, 4'b1000);
    chk("pre_rst.jogada", 32'(if1.db_jogada), 32'd4);
    if1.chaves = 4'b0001;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("midrst.estado", 32'(if1.db_estado), 32'd0);
    chk("midrst.jogada", 32'(if1.db_jogada), 32'd0);
    chk("midrst.leds",   32'(if1.leds),      32'd0);
    if1.chaves = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("posrst.estado", 32'(if1.db_estado), 32'd0);
    iniciar(1, 1'b0);
    jogar(1, 4'b0001);
    chk("posrst.jogada", 32'(if1.db_jogada), 32'd1);
    chk("posrst.estado2", 32'(if1.db_estado), 32'd2);
    chk("posrst.leds",   32'(if1.leds),      32'h1);
    expect_end(4'd9, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    jogar(1, 4'b0001);
    drain("posrst_erro");

    // per-play timeout after 3 correct plays
    iniciar(1, 1'b0);
`ifdef JOGO_TIMEOUT_EN
    expect_end(4'd10, 1'b0, 1'b1, 1'b1, 4'd3, 4'd0);
`endif
    jogar(1, 4'b0001); jogar(1, 4'b0010);
    if1.chaves = 4'b0100;
    for (i = 0; i < 20 && if1.db_estado != 4'd5; i++)
      @(negedge clk);
    chk("tmo.prox", 32'(if1.db_estado), 32'd5);
    if1.chaves = '0;
`ifdef JOGO_TIMEOUT_EN
    c = 0;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (if1.db_estado == 4'd2) c++;
      else if (c > 0) break;
    end
    chk("tmo.ciclos", 32'(c), 32'd3000);
    drain("timeout");
`else
    tick(3500);
    chk("notmo.estado", 32'(if1.db_estado), 32'd2);
    chk("notmo.pronto", 32'(if1.pronto),    32'd0);
    chk("notmo.timeout", 32'(if1.timeout),  32'd0);
`endif

    // progressive mode, 4-play sequence
    iniciar(2, 1'b1);
    expect_end(4'd8, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k <= r; k++) jogar(2, um << k);
      if (r == 0) begin
        chk("prog.rodada1", 32'(if2.db_rodada), 32'd1);
        chk("prog.jogada0", 32'(if2.db_jogada), 32'd0);
      end
    end
    drain("progressivo");

    chk("sb.vazio", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
